// File: rtl/word_assembler32_if.sv
// Byte-in / word-out handshake bundle for word_assembler32.
// The slave side is the assembler; the master side feeds bytes and consumes words.
interface word_assembler32_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_bytes
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_bytes
  );
endinterface

// File: rtl/word_assembler32.sv
// Packs a byte stream into 32-bit words; in_last ends a word early with zero padding.
// One word of storage: while a word waits, in_ready follows out_ready directly.
module word_assembler32 #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  word_assembler32_if.slave   bus
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] data;
  logic [2:0]  bytes;
  logic        accept;
  logic        transfer;

  // Word with byte b placed in the given lane and every other lane zero.
  function automatic logic [31:0] place(input logic [1:0] lane, input logic [7:0] b);
    logic [4:0] sh;
    sh = {lane, 3'b000};
    if (MSB_FIRST) return {b, 24'h0} >> sh;
    else           return {24'h0, b} << sh;
  endfunction

  assign bus.in_ready  = (state == FILL) | bus.out_ready;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = data;
  assign bus.out_bytes = bytes;

  assign accept   = bus.in_valid & bus.in_ready;
  assign transfer = (state == HOLD) & bus.out_ready;

  // NOTE: all state here uses <= so every branch sees the pre-edge values of
  // state/cnt/data; blocking assignments would let one update leak into the next.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= FILL;
      cnt   <= 2'd0;
      data  <= 32'h0;
      bytes <= 3'd0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            data <= data | place(cnt, bus.in_data);
            if (cnt == 2'd3 || bus.in_last) begin
              state <= HOLD;
              bytes <= {1'b0, cnt} + 3'd1;
            end else begin
              cnt <= cnt + 2'd1;
            end
          end
        end
        HOLD: begin
          if (transfer) begin
            if (accept) begin
              // Byte arriving with the transfer starts the next word in lane 0.
              data <= place(2'd0, bus.in_data);
              if (bus.in_last) begin
                cnt   <= 2'd0;
                bytes <= 3'd1;
              end else begin
                state <= FILL;
                cnt   <= 2'd1;
                bytes <= 3'd0;
              end
            end else begin
              state <= FILL;
              cnt   <= 2'd0;
              data  <= 32'h0;
              bytes <= 3'd0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_word_assembler32.sv
// Drives an MSB-first and an LSB-first assembler with identical stimulus and
// checks both against a word-level model of the byte packing rules.
module tb_word_assembler32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic [7:0] in_data = 8'h0;
  logic       out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  word_assembler32_if bus_m ();
  word_assembler32_if bus_l ();

  assign bus_m.in_valid  = in_valid;
  assign bus_m.in_data   = in_data;
  assign bus_m.in_last   = in_last;
  assign bus_m.out_ready = out_ready;
  assign bus_l.in_valid  = in_valid;
  assign bus_l.in_data   = in_data;
  assign bus_l.in_last   = in_last;
  assign bus_l.out_ready = out_ready;

  word_assembler32 #(.MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset_n(reset_n), .bus(bus_m.slave));
  word_assembler32 #(.MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset_n(reset_n), .bus(bus_l.slave));

  // ---------------- word-level reference model (index 0: MSB-first, 1: LSB-first)
  logic [7:0]  cur [2][4];
  int          cur_n [2];
  bit          has_word [2];
  logic [31:0] exp_data [2];
  logic [2:0]  exp_bytes [2];
  int          made [2];
  int          taken [2];

  function automatic logic [31:0] pack(input bit msb, input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3, input int n);
    logic [7:0]  b [4];
    logic [31:0] sum;
    logic [31:0] v;
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    sum = 32'h0;
    for (int i = 0; i < n; i++) begin
      v = {24'h0, b[i]};
      sum = sum + (msb ? (v << (8 * (3 - i))) : (v << (8 * i)));
    end
    return sum;
  endfunction

  task automatic model_step(input int d, input logic rdy, input logic ov,
                            input logic [31:0] od, input logic [2:0] ob);
    bit exp_rdy;
    if (!reset_n) begin
      if (has_word[d]) made[d]--;
      has_word[d] = 1'b0;
      cur_n[d] = 0;
      return;
    end
    exp_rdy = !has_word[d] || out_ready;
    checks++;
    if (ov !== has_word[d]) begin
      errors++;
      $display("FAIL mon_out_valid[%0d] t=%0t got %b want %b", d, $time, ov, has_word[d]);
    end
    checks++;
    if (rdy !== exp_rdy) begin
      errors++;
      $display("FAIL mon_in_ready[%0d] t=%0t got %b want %b", d, $time, rdy, exp_rdy);
    end
    if (has_word[d]) begin
      checks++;
      if (od !== exp_data[d] || ob !== exp_bytes[d]) begin
        errors++;
        $display("FAIL mon_word[%0d] t=%0t got %h/%0d want %h/%0d",
                 d, $time, od, ob, exp_data[d], exp_bytes[d]);
      end
    end else begin
      checks++;
      if (ob !== 3'd0) begin
        errors++;
        $display("FAIL mon_idle_bytes[%0d] t=%0t got %0d want 0", d, $time, ob);
      end
    end
    if (ov === 1'b1 && out_ready) taken[d]++;
    if (has_word[d] && out_ready) has_word[d] = 1'b0;
    if (in_valid && exp_rdy) begin
      cur[d][cur_n[d]] = in_data;
      cur_n[d]++;
      if (in_last || cur_n[d] == 4) begin
        exp_data[d]  = pack(d == 0, cur[d][0], cur[d][1], cur[d][2], cur[d][3], cur_n[d]);
        exp_bytes[d] = 3'(cur_n[d]);
        has_word[d]  = 1'b1;
        made[d]++;
        cur_n[d] = 0;
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cur_n[d] = 0; has_word[d] = 1'b0; made[d] = 0; taken[d] = 0;
      exp_data[d] = 32'h0; exp_bytes[d] = 3'd0;
    end
  end

  always @(negedge clk) begin
    model_step(0, bus_m.in_ready, bus_m.out_valid, bus_m.out_data, bus_m.out_bytes);
    model_step(1, bus_l.in_ready, bus_l.out_valid, bus_l.out_data, bus_l.out_bytes);
  end

  // ---------------- directed and random scenarios
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    in_valid = 1'b1; in_data = b; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if (bus_m.out_valid !== 1'b0 || bus_m.out_data !== 32'h0 || bus_m.out_bytes !== 3'd0 ||
        bus_m.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_msb got v=%b d=%h n=%0d r=%b want 0/0/0/1",
               bus_m.out_valid, bus_m.out_data, bus_m.out_bytes, bus_m.in_ready);
    end
    checks++;
    if (bus_l.out_valid !== 1'b0 || bus_l.out_data !== 32'h0 || bus_l.out_bytes !== 3'd0 ||
        bus_l.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_lsb got v=%b d=%h n=%0d r=%b want 0/0/0/1",
               bus_l.out_valid, bus_l.out_data, bus_l.out_bytes, bus_l.in_ready);
    end
    reset_n = 1'b1; in_valid = 1'b0;
    tick();
    checks++;
    if (bus_m.out_data !== 32'h0 || bus_l.out_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_no_capture got %h/%h want 0/0", bus_m.out_data, bus_l.out_data);
    end
  endtask

  task automatic test_full_word();
    out_ready = 1'b1;
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    checks++;
    if (bus_m.out_valid !== 1'b1 || bus_m.out_data !== 32'h11223344 || bus_m.out_bytes !== 3'd4) begin
      errors++;
      $display("FAIL full_msb got v=%b %h/%0d want 1 11223344/4",
               bus_m.out_valid, bus_m.out_data, bus_m.out_bytes);
    end
    checks++;
    if (bus_l.out_valid !== 1'b1 || bus_l.out_data !== 32'h44332211 || bus_l.out_bytes !== 3'd4) begin
      errors++;
      $display("FAIL full_lsb got v=%b %h/%0d want 1 44332211/4",
               bus_l.out_valid, bus_l.out_data, bus_l.out_bytes);
    end
    tick();
    checks++;
    if (bus_m.out_valid !== 1'b0 || bus_l.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_one_cycle got %b/%b want 0/0", bus_m.out_valid, bus_l.out_valid);
    end
  endtask

  task automatic test_early_end();
    out_ready = 1'b1;
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    checks++;
    if (bus_m.out_valid !== 1'b1 || bus_m.out_data !== 32'hAABB0000 || bus_m.out_bytes !== 3'd2) begin
      errors++;
      $display("FAIL early_msb got v=%b %h/%0d want 1 aabb0000/2",
               bus_m.out_valid, bus_m.out_data, bus_m.out_bytes);
    end
    checks++;
    if (bus_l.out_data !== 32'h0000BBAA || bus_l.out_bytes !== 3'd2) begin
      errors++;
      $display("FAIL early_lsb got %h/%0d want 0000bbaa/2", bus_l.out_data, bus_l.out_bytes);
    end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    in_valid = 1'b1; in_data = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus_m.out_valid !== 1'b1 || bus_m.out_data !== 32'h01020304 || bus_m.in_ready !== 1'b0 ||
          bus_l.out_data !== 32'h04030201 || bus_l.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d got v=%b %h/%h r=%b want 1 01020304/04030201 r=0",
                 i, bus_m.out_valid, bus_m.out_data, bus_l.out_data, bus_m.in_ready);
      end
    end
    out_ready = 1'b1; in_data = 8'h55;
    tick();
    checks++;
    if (bus_m.out_valid !== 1'b0 || bus_m.out_data !== 32'h55000000 || bus_l.out_data !== 32'h00000055) begin
      errors++;
      $display("FAIL release_lane0 got v=%b %h/%h want 0 55000000/00000055",
               bus_m.out_valid, bus_m.out_data, bus_l.out_data);
    end
    send(8'h66, 1'b0); send(8'h77, 1'b0); send(8'h88, 1'b0);
    checks++;
    if (bus_m.out_data !== 32'h55667788 || bus_l.out_data !== 32'h88776655 || bus_m.out_bytes !== 3'd4) begin
      errors++;
      $display("FAIL release_word got %h/%h n=%0d want 55667788/88776655 n=4",
               bus_m.out_data, bus_l.out_data, bus_m.out_bytes);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom_range(1, 255));
      send(b, 1'b1);
      checks++;
      if (bus_m.out_valid !== 1'b1 || bus_m.out_bytes !== 3'd1 || bus_m.out_data !== {b, 24'h0} ||
          bus_l.out_data !== {24'h0, b}) begin
        errors++;
        $display("FAIL b2b_single_%0d got v=%b n=%0d %h/%h want byte %h",
                 i, bus_m.out_valid, bus_m.out_bytes, bus_m.out_data, bus_l.out_data, b);
      end
      in_valid = 1'b1; in_last = 1'b1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    // Streaming full words: a new word must appear every fourth cycle.
    for (int w = 0; w < 3; w++) begin
      for (int k = 0; k < 4; k++) begin
        in_valid = 1'b1; in_data = 8'(16 * w + k + 1); in_last = 1'b0;
        tick();
      end
      checks++;
      if (bus_m.out_valid !== 1'b1 || bus_m.out_data !== pack(1'b1, 8'(16*w+1), 8'(16*w+2), 8'(16*w+3), 8'(16*w+4), 4)) begin
        errors++;
        $display("FAIL b2b_stream_%0d got v=%b %h", w, bus_m.out_valid, bus_m.out_data);
      end
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_word();
    out_ready = 1'b1;
    send(8'h12, 1'b0); send(8'h34, 1'b0);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    send(8'h9A, 1'b0); send(8'hBC, 1'b0); send(8'hDE, 1'b0); send(8'hF0, 1'b0);
    checks++;
    if (bus_m.out_data !== 32'h9ABCDEF0 || bus_l.out_data !== 32'hF0DEBC9A || bus_m.out_bytes !== 3'd4) begin
      errors++;
      $display("FAIL reset_mid got %h/%h n=%0d want 9abcdef0/f0debc9a n=4",
               bus_m.out_data, bus_l.out_data, bus_m.out_bytes);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = (c % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (taken[d] !== made[d] || has_word[d]) begin
        errors++;
        $display("FAIL random_drain[%0d] got taken=%0d want %0d", d, taken[d], made[d]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_early_end();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_word();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
